// File: rtl/complex_matrix_loader.sv
// Serial-to-parallel operand loader for the complex array add/sub ALU.
// Optional WAIT watchdog enabled by defining LOADER_TIMEOUT_EN.
module complex_matrix_loader #(
  parameter int a_row    = 2,
  parameter int a_column = 2,
  parameter int size     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [size-1:0]                in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic                           in_op,
  output logic                           in_ready,
  output logic [a_row*a_column*size-1:0] a_flat,
  output logic [a_row*a_column*size-1:0] b_flat,
  output logic                           a_valid,
  output logic                           b_valid,
  output logic                           start,
  output logic                           operation,
  input  logic                           alu_valid,
  output logic                           busy,
  output logic                           frame_err
);

  localparam int N  = a_row * a_column;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [N*size-1:0] r_a_flat;
  logic [N*size-1:0] r_b_flat;
  logic              r_a_valid;
  logic              r_b_valid;
  logic              r_op;
  logic              r_frame_err;
`ifdef LOADER_TIMEOUT_EN
  logic [15:0]       r_wd;
`endif

  logic w_xfer;
  logic w_last_elem;

  assign in_ready    = (r_state == S_IDLE) || (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign busy        = (r_state != S_IDLE);
  assign start       = (r_state == S_ISSUE);
  assign w_xfer      = in_valid && in_ready;
  assign w_last_elem = (r_cnt == LAST_IDX);

  assign a_flat    = r_a_flat;
  assign b_flat    = r_b_flat;
  assign a_valid   = r_a_valid;
  assign b_valid   = r_b_valid;
  assign operation = r_op;
  assign frame_err = r_frame_err;

  // Frame assembly state machine, buffers and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_a_flat    <= '0;
      r_b_flat    <= '0;
      r_a_valid   <= 1'b0;
      r_b_valid   <= 1'b0;
      r_op        <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      r_wd        <= 16'h0000;
`endif
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE, S_LOAD_A: begin
          if (w_xfer) begin
            r_a_flat[int'(r_cnt)*size +: size] <= in_data;
            // in_last can never be legal while A is still filling
            if (in_last) begin
              r_frame_err <= 1'b1;
              r_a_valid   <= 1'b0;
              r_b_valid   <= 1'b0;
              r_cnt       <= '0;
              r_state     <= S_IDLE;
            end else begin
              if (r_state == S_IDLE) begin
                r_op <= in_op;
              end
              if (w_last_elem) begin
                r_a_valid <= 1'b1;
                r_cnt     <= '0;
                r_state   <= S_LOAD_B;
              end else begin
                r_cnt   <= r_cnt + CW'(1);
                r_state <= S_LOAD_A;
              end
            end
          end
        end
        S_LOAD_B: begin
          if (w_xfer) begin
            r_b_flat[int'(r_cnt)*size +: size] <= in_data;
            if (in_last != w_last_elem) begin
              r_frame_err <= 1'b1;
              r_a_valid   <= 1'b0;
              r_b_valid   <= 1'b0;
              r_cnt       <= '0;
              r_state     <= S_IDLE;
            end else if (w_last_elem) begin
              r_b_valid <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_ISSUE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
`ifdef LOADER_TIMEOUT_EN
          r_wd    <= 16'h0000;
`endif
        end
        S_WAIT: begin
          if (alu_valid) begin
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_state   <= S_IDLE;
`ifdef LOADER_TIMEOUT_EN
          end else if (r_wd == 16'hFFFF) begin
            r_frame_err <= 1'b1;
            r_a_valid   <= 1'b0;
            r_b_valid   <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_wd <= r_wd + 16'h0001;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_matrix_loader.sv
// Scoreboard bench for complex_matrix_loader (2x2, 16-bit elements).
module tb_complex_matrix_loader;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_op;
  logic          in_ready;
  logic [W-1:0]  a_flat;
  logic [W-1:0]  b_flat;
  logic          a_valid;
  logic          b_valid;
  logic          start;
  logic          operation;
  logic          alu_valid;
  logic          busy;
  logic          frame_err;

  complex_matrix_loader #(.a_row(2), .a_column(2), .size(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_op(in_op), .in_ready(in_ready), .a_flat(a_flat), .b_flat(b_flat),
    .a_valid(a_valid), .b_valid(b_valid), .start(start), .operation(operation),
    .alu_valid(alu_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_err;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every start or frame_err pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (start || frame_err)) begin
      if (q.size() == 0) begin
        check("unexpected_event", {62'b0, start, frame_err}, 64'd0);
      end else begin
        e = q.pop_front();
        if (e.is_err) begin
          check("err_pulse", {62'b0, start, frame_err}, 64'd1);
          check("err_valids", {62'b0, a_valid, b_valid}, 64'd0);
        end else begin
          check("start_pulse", {62'b0, start, frame_err}, 64'd2);
          check("a_flat", a_flat, e.a);
          check("b_flat", b_flat, e.b);
          check("operation", {63'b0, operation}, {63'b0, e.op});
          check("issue_valids", {62'b0, a_valid, b_valid}, 64'd3);
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic last, input logic op);
    int   n;
    logic rdy;
    n = 0;
    in_data  = d;
    in_last  = last;
    in_op    = op;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check("send_timeout", {63'b0, rdy}, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                           input bit toggle);
    exp_t e;
    e.is_err = 1'b0; e.a = a; e.b = b; e.op = op;
    q.push_back(e);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) send(a[k*16 +: 16], 1'b0, op);
      else       send(b[(k-4)*16 +: 16], (k == 7), op);
      check($sformatf("a_valid_after_%0d", k), {63'b0, a_valid}, {63'b0, (k >= 3)});
      check($sformatf("start_after_%0d", k), {63'b0, start}, {63'b0, (k == 7)});
      if (toggle && k < 7) begin
        @(posedge clk);
        #1;
      end
    end
    check("ready_in_issue", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("start_one_cycle", {62'b0, start, in_ready}, 64'd0);
    check("busy_wait", {62'b0, busy, b_valid}, 64'd3);
  endtask

  task automatic finish_alu();
    check("ready_before_alu", {63'b0, in_ready}, 64'd0);
    alu_valid = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    check("after_alu", {60'b0, in_ready, busy, a_valid, b_valid}, 64'h8);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.a = '0; e.b = '0; e.op = 1'b0;
    q.push_back(e);
  endtask

  initial begin
    bit seen;
    int cyc;
    rst = 1'b1; in_data = 16'h0; in_valid = 1'b0; in_last = 1'b0; in_op = 1'b0;
    alu_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_flags", {58'b0, in_ready, a_valid, b_valid, start, busy, frame_err}, 64'h20);
    check("reset_a_flat", a_flat, 64'd0);
    check("reset_op", {63'b0, operation}, 64'd0);

    // Back-to-back frame, add
    run_frame(64'h0101_0101_0101_0101, 64'h0203_0203_0203_0203, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    finish_alu();

    // Gappy frame, sub; then WAIT ignores input
    run_frame(64'h0101_0101_0101_0101, 64'h0203_0203_0203_0203, 1'b1, 1'b1);
    seen = 1'b0;
    in_data = 16'hFFFF; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (in_ready || start) seen = 1'b1;
    end
    check("wait_holds", {63'b0, seen}, 64'd0);
    finish_alu();
    check("wait_a_kept", a_flat, 64'h0101_0101_0101_0101);
    check("wait_b_kept", b_flat, 64'h0203_0203_0203_0203);
    check("wait_op_kept", {63'b0, operation}, 64'd1);

    // in_last on element 5 (first B element)
    push_err();
    for (int k = 0; k < 4; k++) send(16'h5555, 1'b0, 1'b0);
    send(16'h6666, 1'b1, 1'b0);
    check("err5_idle", {62'b0, busy, start}, 64'd0);
    check("err5_ready", {63'b0, in_ready}, 64'd1);
    run_frame(64'h4444_3333_2222_1111, 64'hDDDD_CCCC_BBBB_AAAA, 1'b1, 1'b0);
    finish_alu();

    // in_last on the very first element
    push_err();
    send(16'h7777, 1'b1, 1'b1);
    check("err0_idle", {62'b0, busy, start}, 64'd0);

    // Missing in_last on the final B element
    push_err();
    for (int k = 0; k < 8; k++) send(16'h1234, 1'b0, 1'b0);
    check("err7_idle", {62'b0, busy, start}, 64'd0);
    run_frame(64'h0004_0003_0002_0001, 64'h8000_7000_6000_5000, 1'b0, 1'b0);
    finish_alu();

    // Reset during LOAD_B
    for (int k = 0; k < 5; k++) send(16'h0F0F, 1'b0, 1'b1);
    in_data = 16'hF0F0; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_flags", {58'b0, in_ready, a_valid, b_valid, start, busy, frame_err}, 64'h20);
    check("rst_a_flat", a_flat, 64'd0);
    check("rst_b_flat", b_flat, 64'd0);
    check("rst_op", {63'b0, operation}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (start) seen = 1'b1;
    end
    check("rst_no_start", {63'b0, seen}, 64'd0);

`ifdef LOADER_TIMEOUT_EN
    run_frame(64'h0101_0101_0101_0101, 64'h0203_0203_0203_0203, 1'b0, 1'b0);
    push_err();
    cyc = 1;
    while (!frame_err && cyc < 70000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("timeout_seen", {63'b0, frame_err}, 64'd1);
    check("timeout_window", {63'b0, (cyc >= 65535 && cyc <= 65538)}, 64'd1);
    @(posedge clk);
    #1;
    check("timeout_ready", {62'b0, in_ready, busy}, 64'd2);
`else
    cyc = 0;
`endif

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/complex_matrix_loader.md
Name: complex_matrix_loader

Overview:
- Upstream feeder for the complex array add/sub ALU.
- Accepts a serial stream of packed complex elements over a valid/ready handshake: imaginary part in the upper half of each word, real part in the lower half.
- Assembles operand matrices A then B, each in row-major order, into parallel flattened buses.
- Issues a one-cycle start with a_valid/b_valid and the latched operation, then holds the operands until the ALU returns valid before accepting the next frame.

Parameters:
- a_row, 2, rows of A and B
- a_column, 2, columns of A and B
- size, 16, element width in bits (re = [size/2-1:0], im = [size-1:size/2]); must be even

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- in_data  input  size  packed complex element
- in_valid  input  1  in_data valid
- in_last  input  1  marks final element of a frame (element 2*a_row*a_column-1)
- in_op  input  1  operation (0 = add, 1 = sub); sampled with the first element of a frame
- in_ready  output  1  loader accepts in_data this cycle
- a_flat  output  a_row*a_column*size  A elements; element (i,j) at bits [(i*a_column+j)*size +: size]
- b_flat  output  a_row*a_column*size  B elements, same layout
- a_valid  output  1  A buffer complete
- b_valid  output  1  B buffer complete
- start  output  1  one-cycle issue pulse to the ALU
- operation  output  1  latched in_op
- alu_valid  input  1  result-valid pulse from the ALU
- busy  output  1  frame in progress or awaiting result
- frame_err  output  1  one-cycle pulse on framing error

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - in_ready = 1; a_valid, b_valid, start, busy, frame_err = 0.
  - operation = 0; a_flat, b_flat = 0; element counter = 0; state = IDLE.
- Transfer rule: a transfer occurs when in_valid && in_ready at the rising edge. N = a_row*a_column.
- FSM states:
  - IDLE: in_ready = 1, busy = 0. On transfer: write element 0 of A, latch in_op into operation, counter = 1, go to LOAD_A. If that transfer also has in_last = 1, take the framing-error path and stay in IDLE.
  - LOAD_A: each transfer writes A[counter] and increments the counter. The transfer writing element N-1 sets a_valid = 1, resets the counter to 0 and goes to LOAD_B.
  - LOAD_B: each transfer writes B[counter]. The transfer writing element N-1 must have in_last = 1; it sets b_valid = 1 and goes to ISSUE. in_ready = 1 in LOAD_A and LOAD_B.
  - ISSUE: a single cycle. start = 1, in_ready = 0. Go to WAIT.
  - WAIT: in_ready = 0. a_flat, b_flat, operation, a_valid and b_valid are held stable. On alu_valid: clear a_valid and b_valid, go to IDLE. in_ready is 1 again in the next cycle.
- Latency: start asserts exactly one cycle after the clock edge that accepts the final B element.
- Framing error:
  - Trigger: in_last = 1 on any element other than B element N-1, or in_last = 0 on B element N-1.
  - Response: frame_err pulses for 1 cycle, the frame is discarded (a_valid, b_valid cleared, counter 0), state returns to IDLE, start is not issued.
  - Buffer contents are not cleared.
- in_valid while in_ready = 0: ignored, no data is consumed.
- alu_valid outside WAIT: ignored.
- rst mid-frame or during WAIT: return to reset values on the next edge. start is never issued for that frame.
- busy = 1 in all states except IDLE.
- start is never asserted for more than one consecutive cycle.
- No arithmetic is performed; data passes bit-exact.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counts cycles spent in WAIT.
  - If it reaches 16'hFFFF without alu_valid, frame_err pulses, a_valid and b_valid are cleared, and the state returns to IDLE.
  - The watchdog clears on entering WAIT and on rst.
- When undefined: no counter exists, and WAIT holds indefinitely until alu_valid or rst.

Test Plan:
- Reset, then a back-to-back frame of 8 elements: A = 16'h0101 ×4, B = 16'h0203 ×4, in_op = 0, in_last on the 8th → a_valid high after the 4th transfer; start high exactly one cycle after the 8th; every a_flat word is 16'h0101, every b_flat word is 16'h0203; operation = 0; in_ready = 0 until one cycle after alu_valid.
- Same frame with in_valid toggling 1/0 every cycle and in_op = 1 → identical buffers, operation = 1, start after the 8th accepted element only.
- in_last asserted on element 5 → frame_err pulses 1 cycle, no start, busy = 0 on the next cycle; a following correct frame issues start normally.
- In WAIT, drive in_valid = 1 with in_data = 16'hFFFF for 10 cycles, then alu_valid → buffers unchanged (no FFFF written); return to IDLE; a_valid and b_valid = 0.
- Assert rst during LOAD_B (element 6) → all outputs at reset values next cycle; no start within the following 20 cycles of idle input.
- LOADER_TIMEOUT_EN defined, alu_valid never driven → frame_err pulses after 65535 cycles in WAIT; in_ready returns to 1 on the next cycle.
